bypass_fifo_rr_sched: RTL and testbench

// - Drains NUM_REQ bypass FIFOs (FIFOs with a bypass path) onto one shared output channel.
// - Arbitration: round-robin, with bounded bursts.
// - Sits downstream of the per-requester FIFO bank. Drives each FIFO's pop from the FIFO's cnt.
// - Registers the winning head into a single valid/ready output slot.

---
 rtl/bypass_fifo_rr_sched_pkg.sv | 18 +
 rtl/bypass_fifo_rr_sched_rr_pick.sv | 35 +++
 rtl/bypass_fifo_rr_sched.sv | 183 ++++++++++++++++++
 tb/tb_bypass_fifo_rr_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bypass_fifo_rr_sched_pkg.sv
// Shared types and helpers for the bypass-FIFO round-robin scheduler.
// Contents:
//   sched_state_e - scheduler FSM state (SEL: arbitrate, HOLD: burst on lock_id)
//   req_id_w()    - requester index width, minimum 1 bit
//   wrap_inc()    - increment modulo n, valid for any n (power of 2 or not)
package bypass_sched_pkg;

  typedef enum logic {SEL = 1'b0, HOLD = 1'b1} sched_state_e;

  function automatic int unsigned req_id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/bypass_fifo_rr_sched_rr_pick.sv
// Round-robin pick: first set bit of req, searching ptr, ptr+1, ... modulo N.
// Ports:
//   req   in  N    request vector
//   ptr   in  IDW  search start index (must be < N)
//   valid out 1    any request set
//   idx   out IDW  winning index
module rr_pick
  import bypass_sched_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = req_id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    int unsigned w_j;
    valid = 1'b0;
    idx   = '0;
    w_j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = 32'(ptr) + (N - 1 - k);
      if (w_j >= N) w_j = w_j - N;
      if (req[IDW'(w_j)]) begin
        valid = 1'b1;
        idx   = IDW'(w_j);
      end
    end
  end

endmodule

// File: rtl/bypass_fifo_rr_sched.sv
// Drains NUM_REQ bypass FIFOs onto one valid/ready output slot using
// round-robin arbitration with bursts of up to MAX_BURST pops per requester.
// Optional feature macro: BYPASS_SCHED_PUSH_EN (a push into an empty FIFO
// makes it eligible in the same cycle through the FIFO's bypass data path).
// Ports:
//   clk         in  1                clock
//   reset       in  1                synchronous, active-high
//   fifo_cnt    in  NUM_REQ*CNT_W    FIFO occupancy, slice i = FIFO i
//   fifo_data   in  NUM_REQ*WIDTH    FIFO head data, slice i = FIFO i
//   fifo_push   in  NUM_REQ          FIFO push strobes (feature macro only)
//   fifo_pop    out NUM_REQ          one-hot-or-zero pop, combinational
//   out_valid   out 1                output slot holds data
//   out_data    out WIDTH            registered popped head
//   out_req_id  out ID_W             source FIFO of out_data
//   out_ready   in  1                consumer accepts when valid && ready
module bypass_fifo_rr_sched
  import bypass_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned DEPTH     = 8,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
  localparam int unsigned ID_W      = req_id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ*CNT_W-1:0] fifo_cnt,
  input  logic [NUM_REQ*WIDTH-1:0] fifo_data,
  input  logic [NUM_REQ-1:0]       fifo_push,
  output logic [NUM_REQ-1:0]       fifo_pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]          out_req_id,
  input  logic                     out_ready
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  sched_state_e        r_state, w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_W-1:0]     r_lock_id, w_lock_id_nxt;
  logic [BURST_W-1:0]  r_burst_cnt, w_burst_cnt_nxt;

  logic [NUM_REQ-1:0]  w_req;
  logic                w_can_issue;
  logic                w_lock_req;
  logic [ID_W-1:0]     w_lock_inc;
  logic                w_sel_valid, w_rel_valid, w_pick_valid;
  logic [ID_W-1:0]     w_sel_idx, w_rel_idx, w_pick_idx;
  logic                w_grant;
  logic [ID_W-1:0]     w_gid;
  logic [WIDTH-1:0]    w_gnt_data;

  // Request vector; cnt already reflects last cycle's pop.
  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_req[i] = (fifo_cnt[i*CNT_W +: CNT_W] != '0);
`ifdef BYPASS_SCHED_PUSH_EN
      w_req[i] = w_req[i] | fifo_push[i];
`endif
    end
  end

`ifndef BYPASS_SCHED_PUSH_EN
  logic w_unused_push;
  assign w_unused_push = ^fifo_push;
`endif

  assign w_can_issue = !out_valid || out_ready;
  assign w_lock_req  = w_req[r_lock_id];
  assign w_lock_inc  = ID_W'(wrap_inc(32'(r_lock_id), NUM_REQ));

  // Normal arbitration from rr_ptr.
  rr_pick #(.N(NUM_REQ), .IDW(ID_W)) u_sel_pick (
    .req   (w_req),
    .ptr   (r_rr_ptr),
    .valid (w_sel_valid),
    .idx   (w_sel_idx)
  );

  // Same-cycle re-arbitration when the locked FIFO runs dry mid-burst.
  rr_pick #(.N(NUM_REQ), .IDW(ID_W)) u_rel_pick (
    .req   (w_req),
    .ptr   (w_lock_inc),
    .valid (w_rel_valid),
    .idx   (w_rel_idx)
  );

  assign w_pick_valid = (r_state == HOLD) ? w_rel_valid : w_sel_valid;
  assign w_pick_idx   = (r_state == HOLD) ? w_rel_idx   : w_sel_idx;

  // Next-state, grant and bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_lock_id_nxt   = r_lock_id;
    w_burst_cnt_nxt = r_burst_cnt;
    w_grant         = 1'b0;
    w_gid           = r_lock_id;
    if (w_can_issue) begin
      if (r_state == HOLD && w_lock_req) begin
        w_grant         = 1'b1;
        w_burst_cnt_nxt = r_burst_cnt + BURST_W'(1);
        if ((r_burst_cnt + BURST_W'(1)) == BURST_W'(MAX_BURST)) begin
          w_rr_ptr_nxt = w_lock_inc;
          w_state_nxt  = SEL;
        end
      end else begin
        // Release of an empty lock behaves exactly like SEL from lock_id+1.
        if (r_state == HOLD) begin
          w_state_nxt  = SEL;
          w_rr_ptr_nxt = w_lock_inc;
        end
        if (w_pick_valid) begin
          w_grant         = 1'b1;
          w_gid           = w_pick_idx;
          w_lock_id_nxt   = w_pick_idx;
          w_burst_cnt_nxt = BURST_W'(1);
          if (MAX_BURST == 1) begin
            w_rr_ptr_nxt = ID_W'(wrap_inc(32'(w_pick_idx), NUM_REQ));
            w_state_nxt  = SEL;
          end else begin
            w_state_nxt  = HOLD;
          end
        end
      end
    end
  end

  // Pop strobe and head-data mux for the granted FIFO.
  always_comb begin
    fifo_pop   = '0;
    w_gnt_data = '0;
    if (w_grant && !reset) fifo_pop[w_gid] = 1'b1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_gid) w_gnt_data = fifo_data[i*WIDTH +: WIDTH];
    end
  end

  // State and output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEL;
      r_rr_ptr    <= '0;
      r_lock_id   <= '0;
      r_burst_cnt <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_req_id  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_lock_id   <= w_lock_id_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      if (w_grant) begin
        out_valid  <= 1'b1;
        out_data   <= w_gnt_data;
        out_req_id <= w_gid;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // Pop must be one-hot-or-zero and only target a FIFO that has a word.
  always @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(fifo_pop));
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef BYPASS_SCHED_PUSH_EN
        assert (!fifo_pop[i] || (fifo_cnt[i*CNT_W +: CNT_W] != '0) || fifo_push[i]);
`else
        assert (!fifo_pop[i] || (fifo_cnt[i*CNT_W +: CNT_W] != '0));
`endif
      end
    end
  end
`endif

endmodule

// File: tb/tb_bypass_fifo_rr_sched.sv
// Self-checking bench for bypass_fifo_rr_sched: FIFO contents are held in
// bench arrays, and a queue-level scheduler model predicts pops and outputs.
module tb_bypass_fifo_rr_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int MB = 4;
  localparam int CW = $clog2(D + 1);
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*CW-1:0] fifo_cnt;
  logic [N*W-1:0]  fifo_data;
  logic [N-1:0]  fifo_push;
  logic [N-1:0]  fifo_pop;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_req_id;
  logic          out_ready;

  always #5 clk = ~clk;

  bypass_fifo_rr_sched #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_cnt   (fifo_cnt),
    .fifo_data  (fifo_data),
    .fifo_push  (fifo_push),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_req_id (out_req_id),
    .out_ready  (out_ready)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // FIFO contents (index 0 is the head).
  logic [W-1:0] fm [N][D];
  int           fn [N];

  // Scheduler model: owner = requester holding the burst (-1 when arbitrating).
  int           m_owner, m_pops, m_ptr;
  logic         e_valid;
  logic [W-1:0] e_data;
  int           e_id;
  logic [N-1:0] last_pop;

  task automatic model_reset();
    for (int i = 0; i < N; i++) fn[i] = 0;
    m_owner = -1; m_pops = 0; m_ptr = 0;
    e_valid = 1'b0; e_data = '0; e_id = 0;
  endtask

  task automatic load(input int i, input int cnt, input logic [W-1:0] base);
    for (int j = 0; j < cnt; j++) fm[i][j] = base + W'(j);
    fn[i] = cnt;
  endtask

  // One clock cycle: drive at negedge, check pop, apply edge, check outputs.
  task automatic step(input bit rst, input bit rdy, input logic [N-1:0] pen, input logic [W-1:0] pval);
    logic [N-1:0] req, push, exp_pop;
    logic [W-1:0] word;
    int g;
    bit can;
    push = '0;
    req  = '0;
    for (int i = 0; i < N; i++) begin
      push[i] = pen[i] && (fn[i] < D);
      fifo_cnt[i*CW +: CW] = CW'(fn[i]);
      fifo_data[i*W +: W]  = (fn[i] > 0) ? fm[i][0] : (push[i] ? pval : '0);
      req[i] = (fn[i] > 0);
`ifdef BYPASS_SCHED_PUSH_EN
      req[i] = req[i] | push[i];
`endif
    end
    reset     = rst;
    out_ready = rdy;
    fifo_push = push;

    g   = -1;
    can = !e_valid || rdy;
    if (!rst && can) begin
      if (m_owner >= 0 && !req[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
      if (m_owner >= 0) g = m_owner;
      else for (int k = 0; k < N; k++) if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        if (g == m_owner) begin
          m_pops++;
          if (m_pops == MB) begin m_ptr = (g + 1) % N; m_owner = -1; end
        end else begin
          m_owner = g; m_pops = 1;
          if (MB == 1) begin m_ptr = (g + 1) % N; m_owner = -1; end
        end
      end
    end
    exp_pop = '0;
    if (g >= 0) exp_pop[g] = 1'b1;

    #1;
    last_pop = fifo_pop;
    check_eq("pop", 32'(fifo_pop), 32'(exp_pop));

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) if (push[i]) begin fm[i][fn[i]] = pval; fn[i]++; end
      if (g >= 0) begin
        word = fm[g][0];
        for (int j = 0; j < D - 1; j++) fm[g][j] = fm[g][j+1];
        fn[g]--;
        e_valid = 1'b1; e_data = word; e_id = g;
      end else if (can && rdy) begin
        e_valid = 1'b0;
      end
    end
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(e_valid));
    check_eq("out_data", 32'(out_data), 32'(e_data));
    check_eq("out_req_id", 32'(out_req_id), 32'(e_id));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; fifo_push = '0; fifo_cnt = '0; fifo_data = '0;
    last_pop = '0;
    model_reset();
    @(negedge clk);

    // Reset state.
    step(1, 1, '0, '0);
    step(1, 1, '0, '0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);

    // Single FIFO holding 3 words.
    load(1, 3, 8'h10);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, '0, '0);
      check_eq("t1_pop", 32'(last_pop), 32'h2);
      check_eq("t1_id", 32'(out_req_id), 32'd1);
      check_eq("t1_valid", 32'(out_valid), 32'd1);
    end
    step(0, 1, '0, '0);
    check_eq("t1_idle", 32'(out_valid), 32'd0);

    // All FIFOs full: bursts of 4 in order.
    step(1, 1, '0, '0);
    for (int i = 0; i < N; i++) load(i, D, W'(8'h20 * (i + 1)));
    for (int k = 0; k < 20; k++) begin
      step(0, 1, '0, '0);
      check_eq("t2_seq", 32'(out_req_id), 32'((k / 4) % 4));
    end

    // Locked FIFO drains mid-burst: switch without a bubble, then pointer wraps.
    step(1, 1, '0, '0);
    load(2, 2, 8'h60);
    load(3, 2, 8'h70);
    step(0, 1, '0, '0);
    step(0, 1, '0, '0);
    step(0, 1, '0, '0);
    check_eq("t3_switch", 32'(last_pop), 32'h8);
    step(0, 1, '0, '0);
    check_eq("t3_hold3", 32'(last_pop), 32'h8);
    step(0, 1, '0, '0);
    check_eq("t3_release", 32'(last_pop), 32'h0);
    load(1, 1, 8'h81);
    load(3, 1, 8'h83);
    step(0, 1, '0, '0);
    check_eq("t3_ptr0", 32'(last_pop), 32'h2);

    // Stall for 5 cycles.
    step(1, 1, '0, '0);
    load(0, 8, 8'h40);
    step(0, 1, '0, '0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, '0, '0);
      check_eq("t4_nopop", 32'(last_pop), 32'h0);
      check_eq("t4_data", 32'(out_data), 32'h40);
      check_eq("t4_id", 32'(out_req_id), 32'd0);
    end
    step(0, 1, '0, '0);
    check_eq("t4_resume", 32'(last_pop), 32'h1);
    check_eq("t4_next", 32'(out_data), 32'h41);

    // Reset during a burst on FIFO2.
    step(1, 1, '0, '0);
    load(2, 8, 8'h90);
    step(0, 1, '0, '0);
    step(0, 1, '0, '0);
    step(1, 1, '0, '0);
    check_eq("t5_valid", 32'(out_valid), 32'd0);
    load(0, 2, 8'hB0);
    load(2, 2, 8'hC0);
    step(0, 1, '0, '0);
    check_eq("t5_first", 32'(last_pop), 32'h1);

    // Push into an empty FIFO.
    step(1, 1, '0, '0);
    step(0, 1, 4'b1000, 8'hA5);
`ifdef BYPASS_SCHED_PUSH_EN
    check_eq("t6_pop", 32'(last_pop), 32'h8);
`else
    check_eq("t6_nopop", 32'(last_pop), 32'h0);
    step(0, 1, '0, '0);
    check_eq("t6_pop", 32'(last_pop), 32'h8);
`endif
    check_eq("t6_data", 32'(out_data), 32'hA5);
    check_eq("t6_id", 32'(out_req_id), 32'd3);

    // Random traffic, back-pressure and occasional reset.
    step(1, 1, '0, '0);
    for (int k = 0; k < 800; k++) begin
      step(($urandom % 150) == 0, ($urandom % 4) != 0, N'($urandom), W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
